spi_word_rx: RTL and testbench

SPI slave word receiver: consumes the synchronized edge strobes and serial data from the SPI input synchronizer and assembles MSB-first words of WIDTH bits. Completed words go to the FIR sample path through a valid/ready output register. Optionally shifts a response word out on MISO in the same frame. Sits directly downstream of the synchronizer/edge detector and upstream of the FIR input.

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_word_rx_if.sv | 22 ++
 rtl/spi_tx_shift.sv | 29 ++
 rtl/spi_word_rx.sv | 122 ++++++++++++
 tb/tb_spi_word_rx.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI word receiver.
package spi_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    localparam int SPI_WORD_W = 16;

endpackage

// File: rtl/spi_word_rx_if.sv
// Received-word valid/ready channel between spi_word_rx and the FIR input.
interface spi_word_rx_if #(
    parameter int WIDTH = 16
);

    logic [WIDTH-1:0] rx_data;
    logic             rx_valid;
    logic             rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/spi_tx_shift.sv
// MISO response shift register: loaded at frame start, shifted on SCK falling edges.
module spi_tx_shift #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic             active_i,
    input  logic [WIDTH-1:0] tx_data_i,
    output logic             miso_o
);

    logic [WIDTH-1:0] tx_sr_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tx_sr_q <= '0;
        end else if (load_i) begin
            tx_sr_q <= tx_data_i;
        end else if (shift_i) begin
            tx_sr_q <= {tx_sr_q[WIDTH-2:0], 1'b0};
        end
    end

    // MSB is presented before the first SCK rise, as SPI mode 0 requires.
    assign miso_o = active_i & tx_sr_q[WIDTH-1];

endmodule

// File: rtl/spi_word_rx.sv
// SPI slave word receiver: MSB-first words into a valid/ready output register.
// Optional MISO response path enabled by defining SPI_WORD_RX_MISO_EN.
module spi_word_rx
    import spi_pkg::*;
#(
    parameter int WIDTH = SPI_WORD_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             nss_fall,
    input  logic             rise_edge,
    input  logic             fall_edge,
    input  logic             mosi_s,
    spi_word_rx_if.master    rx,
    output logic             overrun,
    output logic             busy,
    input  logic [WIDTH-1:0] tx_data,
    output logic             miso
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    spi_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;
    logic [WIDTH-1:0] rx_data_q;
    logic             rx_valid_q;
    logic             overrun_q;
    logic             busy_q;
    logic             bit_take;
    logic             word_done;

    // A frame restart outranks a coincident sample strobe.
    assign bit_take  = (state_q == SHIFT) && rise_edge && !nss_fall;
    assign word_done = bit_take && (cnt_q == CNT_LAST);
    assign sr_d      = {sr_q[WIDTH-2:0], mosi_s};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sr_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            overrun_q <= 1'b0;

            if (rx_valid_q && rx.rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            // A held word is only replaced if it is consumed this same cycle.
            if (word_done) begin
                if (!rx_valid_q || rx.rx_ready) begin
                    rx_data_q  <= sr_d;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end

            case (state_q)
                IDLE: begin
                    if (nss_fall) begin
                        state_q <= SHIFT;
                        cnt_q   <= '0;
                        sr_q    <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (nss_fall) begin
                        cnt_q <= '0;
                        sr_q  <= '0;
                    end else if (bit_take) begin
                        sr_q <= sr_d;
                        if (word_done) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx.rx_data  = rx_data_q;
    assign rx.rx_valid = rx_valid_q;
    assign overrun     = overrun_q;
    assign busy        = busy_q;

`ifdef SPI_WORD_RX_MISO_EN
    spi_tx_shift #(
        .WIDTH (WIDTH)
    ) u_tx_shift (
        .clk       (clk),
        .n_rst     (n_rst),
        .load_i    (nss_fall),
        .shift_i   (fall_edge && (state_q == SHIFT)),
        .active_i  (state_q == SHIFT),
        .tx_data_i (tx_data),
        .miso_o    (miso)
    );
`else
    logic unused_tx;
    assign unused_tx = ^{tx_data, fall_edge};
    assign miso      = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_rx.sv
// Bench for spi_word_rx: vector table of frames, scoreboard on the rx channel, corner sequences.
module tb_spi_word_rx;

    localparam int W = 16;

    typedef struct {
        logic [W-1:0] word;
        logic [W-1:0] exp_data;
        logic         exp_ovr;
    } vec_t;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         nss_fall = 1'b0;
    logic         rise_edge = 1'b0;
    logic         fall_edge = 1'b0;
    logic         mosi_s = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         overrun;
    logic         busy;
    logic         miso;

    spi_word_rx_if #(.WIDTH(W)) rx_if ();

    spi_word_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .nss_fall  (nss_fall),
        .rise_edge (rise_edge),
        .fall_edge (fall_edge),
        .mosi_s    (mosi_s),
        .rx        (rx_if),
        .overrun   (overrun),
        .busy      (busy),
        .tx_data   (tx_data),
        .miso      (miso)
    );

    always #5 clk = ~clk;

    int           checks = 0;
    int           fails  = 0;
    logic [W-1:0] exp_q[$];
    logic         miso_seen[W];
    vec_t         vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        nss_fall = 1'b1;
        tick();
        nss_fall = 1'b0;
    endtask

    // Sends the n most significant bits of w; returns just after the last sampling edge.
    task automatic send_bits(input logic [W-1:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            miso_seen[i] = miso;
            mosi_s       = w[W-1-i];
            rise_edge    = 1'b1;
            tick();
            rise_edge = 1'b0;
            if (i < n - 1) begin
                fall_edge = 1'b1;
                tick();
                fall_edge = 1'b0;
            end
        end
    endtask

    // Scoreboard: every accepted word must match the oldest expected word.
    always @(negedge clk) begin
        if (n_rst && rx_if.rx_valid && rx_if.rx_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_pending", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("sb_word", 32'(rx_if.rx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rx_if.rx_ready = 1'b0;
        vecs[0] = '{word: 16'hA5C3, exp_data: 16'hA5C3, exp_ovr: 1'b0};
        vecs[1] = '{word: 16'h0000, exp_data: 16'h0000, exp_ovr: 1'b0};
        vecs[2] = '{word: 16'hFFFF, exp_data: 16'hFFFF, exp_ovr: 1'b0};
        vecs[3] = '{word: 16'h8001, exp_data: 16'h8001, exp_ovr: 1'b0};
        vecs[4] = '{word: 16'h5A0F, exp_data: 16'h5A0F, exp_ovr: 1'b0};

        #2;
        chk("rst_valid", rx_if.rx_valid, 0);
        chk("rst_data", rx_if.rx_data, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);
        chk("rst_miso", miso, 0);
        repeat (2) @(posedge clk);
        #1 n_rst = 1'b1;
        tick();

        // Vector table, consumer always ready
        rx_if.rx_ready = 1'b1;
        for (int v = 0; v < 5; v++) begin
            start_frame();
            chk("tbl_busy_start", busy, 1);
            exp_q.push_back(vecs[v].exp_data);
            send_bits(vecs[v].word, W);
            chk("tbl_valid", rx_if.rx_valid, 1);
            chk("tbl_data", rx_if.rx_data, vecs[v].exp_data);
            chk("tbl_overrun", overrun, vecs[v].exp_ovr);
            chk("tbl_busy_end", busy, 0);
            tick();
            chk("tbl_valid_clear", rx_if.rx_valid, 0);
            chk("tbl_overrun_low", overrun, 0);
        end

        // Back-pressure: second word dropped with a single overrun pulse
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(16'h1234);
        start_frame();
        send_bits(16'h1234, W);
        chk("bp_valid1", rx_if.rx_valid, 1);
        chk("bp_data1", rx_if.rx_data, 16'h1234);
        chk("bp_ovr1", overrun, 0);
        tick();
        start_frame();
        send_bits(16'hBEEF, W);
        chk("bp_ovr2", overrun, 1);
        chk("bp_data2", rx_if.rx_data, 16'h1234);
        chk("bp_valid2", rx_if.rx_valid, 1);
        tick();
        chk("bp_ovr_pulse", overrun, 0);
        rx_if.rx_ready = 1'b1;
        tick();
        chk("bp_valid_clear", rx_if.rx_valid, 0);
        chk("bp_data_hold", rx_if.rx_data, 16'h1234);

        // Abort after 7 bits; restart coincides with a sample strobe
        start_frame();
        send_bits(16'hFFFF, 7);
        nss_fall  = 1'b1;
        rise_edge = 1'b1;
        mosi_s    = 1'b1;
        tick();
        nss_fall  = 1'b0;
        rise_edge = 1'b0;
        chk("abort_busy", busy, 1);
        chk("abort_no_valid", rx_if.rx_valid, 0);
        exp_q.push_back(16'h00FF);
        send_bits(16'h00FF, W);
        chk("abort_data", rx_if.rx_data, 16'h00FF);
        chk("abort_valid", rx_if.rx_valid, 1);
        tick();

        // Strobes in IDLE and a 17th strobe after completion are ignored
        for (int i = 0; i < 5; i++) begin
            mosi_s    = 1'b1;
            rise_edge = 1'b1;
            tick();
            rise_edge = 1'b0;
            tick();
        end
        chk("idle_busy", busy, 0);
        chk("idle_valid", rx_if.rx_valid, 0);
        chk("idle_data", rx_if.rx_data, 16'h00FF);
        exp_q.push_back(16'h3C3C);
        start_frame();
        send_bits(16'h3C3C, W);
        chk("x17_data", rx_if.rx_data, 16'h3C3C);
        rise_edge = 1'b1;
        tick();
        rise_edge = 1'b0;
        chk("x17_busy", busy, 0);
        chk("x17_valid", rx_if.rx_valid, 0);
        chk("x17_ovr", overrun, 0);
        tick();
        chk("x17_data_hold", rx_if.rx_data, 16'h3C3C);

        // Reset mid-frame with a word pending
        rx_if.rx_ready = 1'b0;
        start_frame();
        send_bits(16'h0F0F, W);
        tick();
        start_frame();
        send_bits(16'hFFFF, 9);
        #2 n_rst = 1'b0;
        #1;
        chk("mrst_valid", rx_if.rx_valid, 0);
        chk("mrst_data", rx_if.rx_data, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_ovr", overrun, 0);
        chk("mrst_miso", miso, 0);
        #3 n_rst = 1'b1;
        tick();
        chk("mrst_idle", busy, 0);
        rx_if.rx_ready = 1'b1;
        exp_q.push_back(16'h5555);
        start_frame();
        send_bits(16'h5555, W);
        chk("mrst_next_data", rx_if.rx_data, 16'h5555);
        chk("mrst_next_valid", rx_if.rx_valid, 1);
        tick();

        // MISO response sequence
        tx_data = 16'hC001;
        chk("miso_idle_pre", miso, 0);
        exp_q.push_back(16'h0000);
        start_frame();
        send_bits(16'h0000, W);
        for (int i = 0; i < W; i++) begin
`ifdef SPI_WORD_RX_MISO_EN
            chk($sformatf("miso_bit%0d", i), miso_seen[i], tx_data[W-1-i]);
`else
            chk($sformatf("miso_bit%0d", i), miso_seen[i], 0);
`endif
        end
        chk("miso_idle_post", miso, 0);
        tx_data = 16'hFFFF;
        repeat (3) tick();
        chk("miso_idle_late", miso, 0);

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
